// File: rtl/ccu_snoop_sequencer.sv
// Broadcasts one coherent snoop to every port but the initiator and
// folds the returned CR responses into a single summary for the decoder.
module ccu_snoop_sequencer #(
    parameter  int unsigned NoMstPorts = 4,
    parameter  int unsigned AddrWidth  = 64,
    localparam int unsigned MstIdxBits = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  logic [3:0]              req_snoop_i,
    input  logic [2:0]              req_prot_i,
    input  logic [MstIdxBits-1:0]   req_initiator_i,
    output logic [NoMstPorts-1:0]   ac_valid_o,
    input  logic [NoMstPorts-1:0]   ac_ready_i,
    output logic [AddrWidth-1:0]    ac_addr_o,
    output logic [3:0]              ac_snoop_o,
    output logic [2:0]              ac_prot_o,
    input  logic [NoMstPorts-1:0]   cr_valid_i,
    output logic [NoMstPorts-1:0]   cr_ready_o,
    input  logic [NoMstPorts*5-1:0] cr_resp_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_shared_o,
    output logic                    rsp_dirty_o,
    output logic                    rsp_error_o,
    output logic [NoMstPorts-1:0]   rsp_data_available_o,
    output logic [MstIdxBits-1:0]   rsp_first_responder_o
);

    typedef enum logic [1:0] {
        IDLE,
        SNOOP,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic [3:0]              snoop_q, snoop_d;
    logic [2:0]              prot_q, prot_d;
    logic [NoMstPorts-1:0]   target_q, target_d;
    logic [NoMstPorts-1:0]   ac_sent_q, ac_sent_d;
    logic [NoMstPorts-1:0]   cr_recv_q, cr_recv_d;
    logic                    shared_q, shared_d;
    logic                    dirty_q, dirty_d;
    logic                    error_q, error_d;
    logic [NoMstPorts-1:0]   data_avail_q, data_avail_d;
    logic [MstIdxBits-1:0]   first_q, first_d;
    logic                    first_found_q, first_found_d;

    logic [NoMstPorts-1:0]   target_new;
    logic [NoMstPorts-1:0]   ac_hs;
    logic [NoMstPorts-1:0]   cr_hs;
    logic                    dt_hit;
    logic [MstIdxBits-1:0]   dt_idx;

    always_comb begin
        for (int i = 0; i < NoMstPorts; i++) begin
            target_new[i] = (MstIdxBits'(i) != req_initiator_i);
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        snoop_d       = snoop_q;
        prot_d        = prot_q;
        target_d      = target_q;
        ac_sent_d     = ac_sent_q;
        cr_recv_d     = cr_recv_q;
        shared_d      = shared_q;
        dirty_d       = dirty_q;
        error_d       = error_q;
        data_avail_d  = data_avail_q;
        first_d       = first_q;
        first_found_d = first_found_q;
        req_ready_o   = 1'b0;
        ac_valid_o    = '0;
        cr_ready_o    = '0;
        rsp_valid_o   = 1'b0;
        ac_hs         = '0;
        cr_hs         = '0;
        dt_hit        = 1'b0;
        dt_idx        = '0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d        = req_addr_i;
                    snoop_d       = req_snoop_i;
                    prot_d        = req_prot_i;
                    target_d      = target_new;
                    ac_sent_d     = '0;
                    cr_recv_d     = '0;
                    shared_d      = 1'b0;
                    dirty_d       = 1'b0;
                    error_d       = 1'b0;
                    data_avail_d  = '0;
                    first_d       = '0;
                    first_found_d = 1'b0;
                    state_d       = (|target_new) ? SNOOP : RESP;
                end
            end
            SNOOP: begin
                ac_valid_o = target_q & ~ac_sent_q;
                cr_ready_o = ac_sent_q & ~cr_recv_q;
                ac_hs      = ac_valid_o & ac_ready_i;
                cr_hs      = cr_ready_o & cr_valid_i;
                ac_sent_d  = ac_sent_q | ac_hs;
                cr_recv_d  = cr_recv_q | cr_hs;
                for (int i = 0; i < NoMstPorts; i++) begin
                    if (cr_hs[i]) begin
                        data_avail_d[i] = cr_resp_i[5*i];
                        error_d         = error_d | cr_resp_i[5*i+1];
                        dirty_d         = dirty_d | cr_resp_i[5*i+2];
                        shared_d        = shared_d | cr_resp_i[5*i+3];
                        // ascending scan: lowest index wins a same-cycle tie
                        if (cr_resp_i[5*i] && !dt_hit) begin
                            dt_hit = 1'b1;
                            dt_idx = MstIdxBits'(i);
                        end
                    end
                end
                if (dt_hit && !first_found_q) begin
                    first_d       = dt_idx;
                    first_found_d = 1'b1;
                end
                if (cr_recv_d == target_q) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            snoop_q       <= '0;
            prot_q        <= '0;
            target_q      <= '0;
            ac_sent_q     <= '0;
            cr_recv_q     <= '0;
            shared_q      <= 1'b0;
            dirty_q       <= 1'b0;
            error_q       <= 1'b0;
            data_avail_q  <= '0;
            first_q       <= '0;
            first_found_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            snoop_q       <= snoop_d;
            prot_q        <= prot_d;
            target_q      <= target_d;
            ac_sent_q     <= ac_sent_d;
            cr_recv_q     <= cr_recv_d;
            shared_q      <= shared_d;
            dirty_q       <= dirty_d;
            error_q       <= error_d;
            data_avail_q  <= data_avail_d;
            first_q       <= first_d;
            first_found_q <= first_found_d;
        end
    end

    assign ac_addr_o             = addr_q;
    assign ac_snoop_o            = snoop_q;
    assign ac_prot_o             = prot_q;
    assign rsp_shared_o          = shared_q;
    assign rsp_dirty_o           = dirty_q;
    assign rsp_error_o           = error_q;
    assign rsp_data_available_o  = data_avail_q;
    assign rsp_first_responder_o = first_q;

endmodule
